// File: rtl/cbus_arbiter_rr.sv
// N-input cbus arbiter: fixed-priority (with starvation guard) or round-robin
// selection, one grant per transaction, one IDLE cycle between grants.
package cbus_arbiter_rr_pkg;
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;
endpackage

module cbus_arbiter_rr
    import cbus_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 2,
    parameter int unsigned ROUND_ROBIN  = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic       [IDX_W-1:0]      grant_idx,
    output logic                        busy
);
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q [NUM_INPUTS];
    logic [CNT_W-1:0] cnt_d [NUM_INPUTS];

    logic [NUM_INPUTS-1:0] valid_vec;
    logic [IDX_W-1:0]      win;
    logic                  found;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= int'(NUM_INPUTS)) idx = idx - int'(NUM_INPUTS);
                if (!found && valid_vec[idx]) begin
                    win   = IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            // A starved requester overrides plain index priority.
            if (STARVE_LIMIT != 0) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (!found && valid_vec[i] && cnt_q[i] == CNT_W'(STARVE_LIMIT)) begin
                        win   = IDX_W'(i);
                        found = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!found && valid_vec[i]) begin
                    win   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        oreq    = '0;
        iresps  = '0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|valid_vec) begin
                    state_d = GRANT;
                    gidx_d  = win;
                    if (ROUND_ROBIN == 0 && STARVE_LIMIT != 0) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            if (!valid_vec[i] || IDX_W'(i) == win) begin
                                cnt_d[i] = '0;
                            end else if (cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                end
            end
            GRANT: begin
                busy           = 1'b1;
                oreq           = ireqs[gidx_q];
                iresps[gidx_q] = oresp;
                // Completion and abort both release the bus and advance the pointer.
                if ((oresp.ready && oresp.last) || !ireqs[gidx_q].valid) begin
                    state_d = IDLE;
                    if (ROUND_ROBIN != 0) begin
                        rr_d = (gidx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : gidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            rr_q    <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grant_idx = gidx_q;
endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Randomized bench: a round-robin and a fixed-priority (starve limit 2) arbiter,
// both 3 inputs, each checked every cycle against a transaction-level model.
module tb_cbus_arbiter_rr;
    import cbus_arbiter_rr_pkg::*;

    localparam int N     = 3;
    localparam int LIMIT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_req_t  [N-1:0] ireqs_v  [2];
    cbus_resp_t [N-1:0] iresps_v [2];
    cbus_req_t          oreq_v   [2];
    cbus_resp_t         oresp_v  [2];
    logic [1:0]         gidx_v   [2];
    logic               busy_v   [2];

    cbus_arbiter_rr #(.NUM_INPUTS(N), .ROUND_ROBIN(1), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(ireqs_v[0]), .iresps(iresps_v[0]),
        .oreq(oreq_v[0]), .oresp(oresp_v[0]), .grant_idx(gidx_v[0]), .busy(busy_v[0]));

    cbus_arbiter_rr #(.NUM_INPUTS(N), .ROUND_ROBIN(0), .STARVE_LIMIT(LIMIT)) dut_fx (
        .clk(clk), .reset(reset), .ireqs(ireqs_v[1]), .iresps(iresps_v[1]),
        .oreq(oreq_v[1]), .oresp(oresp_v[1]), .grant_idx(gidx_v[1]), .busy(busy_v[1]));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner = -1 when idle, otherwise the granted master.
    int owner [2];
    int gidx  [2];
    int rr    [2];
    int cnt   [2][N];
    bit pending [2][N];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            gidx[d]  = 0;
            rr[d]    = 0;
            for (int i = 0; i < N; i++) cnt[d][i] = 0;
        end
    endtask

    function automatic int pick(input int d);
        int w;
        w = -1;
        if (d == 0) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && ireqs_v[d][(rr[d] + k) % N].valid) w = (rr[d] + k) % N;
        end else begin
            for (int i = 0; i < N; i++)
                if (w < 0 && ireqs_v[d][i].valid && cnt[d][i] >= LIMIT) w = i;
            for (int i = 0; i < N; i++)
                if (w < 0 && ireqs_v[d][i].valid) w = i;
        end
        return w;
    endfunction

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (pending[d][i] && owner[d] == i && $urandom_range(11) == 0) begin
                    pending[d][i] = 1'b0;          // master aborts mid-burst
                    ireqs_v[d][i].valid = 1'b0;
                end else if (!pending[d][i]) begin
                    if ($urandom_range(3) != 0) begin
                        pending[d][i] = 1'b1;
                        ireqs_v[d][i] = '{valid: 1'b1, we: 1'($urandom), addr: $urandom, wdata: $urandom};
                    end else begin
                        ireqs_v[d][i] = '0;
                    end
                end
            end
            oresp_v[d] = '{ready: ($urandom_range(3) != 0), last: ($urandom_range(2) == 0), rdata: $urandom};
        end
    endtask

    task automatic check_outputs();
        cbus_req_t          exp_req;
        cbus_resp_t [N-1:0] exp_resps;
        for (int d = 0; d < 2; d++) begin
            exp_req   = '0;
            exp_resps = '0;
            if (owner[d] >= 0) begin
                exp_req             = ireqs_v[d][owner[d]];
                exp_resps[owner[d]] = oresp_v[d];
            end
            chk($sformatf("busy[%0d]", d), busy_v[d], owner[d] >= 0);
            chk($sformatf("grant_idx[%0d]", d), gidx_v[d], gidx[d]);
            chk($sformatf("oreq[%0d]", d), oreq_v[d], exp_req);
            chk($sformatf("iresps[%0d]", d), iresps_v[d], exp_resps);
        end
    endtask

    task automatic model_step();
        int w;
        bit any;
        for (int d = 0; d < 2; d++) begin
            if (owner[d] < 0) begin
                w = pick(d);
                if (w >= 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (!ireqs_v[d][i].valid || i == w) cnt[d][i] = 0;
                        else if (cnt[d][i] < LIMIT)          cnt[d][i]++;
                    end
                    owner[d] = w;
                    gidx[d]  = w;
                end
            end else begin
                any = oresp_v[d].ready && oresp_v[d].last;
                if (any) pending[d][owner[d]] = 1'b0;
                if (any || !ireqs_v[d][owner[d]].valid) begin
                    rr[d]    = (owner[d] + 1) % N;
                    owner[d] = -1;
                end
            end
        end
    endtask

    task automatic cycle_body();
        drive();
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cycle_body();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy[%0d]", tag, d), busy_v[d], 1'b0);
            chk($sformatf("%s_gidx[%0d]", tag, d), gidx_v[d], 2'd0);
            chk($sformatf("%s_oreq[%0d]", tag, d), oreq_v[d], '0);
            chk($sformatf("%s_iresps[%0d]", tag, d), iresps_v[d], '0);
        end
    endtask

    initial begin
        int tries;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) pending[d][i] = 1'b0;
            ireqs_v[d] = '0;
            oresp_v[d] = '0;
        end
        model_reset();
        @(negedge clk);
        drive();
        @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        cycle_body();
        run_cycles(2000);

        tries = 0;
        while (!(owner[0] >= 0 && owner[1] >= 0) && tries < 200) begin
            run_cycles(1);
            tries++;
        end
        chk("wait_both_granted", tries < 200, 1'b1);

        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle_body();
        run_cycles(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
